// File: rtl/mips32_core_if.sv
// Word-addressed memory bus between the core and its instruction/data memories.
// Carries only the word index; byte offset bits stay inside the core.
interface mips32_core_if #(
  parameter int unsigned AW = 5
);
  logic          we;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;

  modport master (output we, addr, wdata, input rdata);
  modport slave  (input we, addr, wdata, output rdata);
endinterface

// File: rtl/mips32_core.sv
// Single-cycle MIPS32 subset CPU: fetch, decode, execute, memory and writeback in one clock.
// Owns instruction memory (imemory), register file (registers) and data memory (main_memory).

// Async-read, sync-write word memory; shared by instruction and data storage.
module mips32_ram #(
  parameter int unsigned WORDS = 32
) (
  input logic         clk,
  mips32_core_if.slave bus
);
  logic [31:0] memory [WORDS];

  always_ff @(posedge clk) begin
    if (bus.we) memory[bus.addr] <= bus.wdata;
  end

  assign bus.rdata = memory[bus.addr];
endmodule

// 32x32 register file, two async read ports; $0 is hard-wired to zero on read.
module mips32_regfile (
  input  logic        clk,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr_a,
  input  logic [4:0]  i_raddr_b,
  output logic [31:0] o_rdata_a,
  output logic [31:0] o_rdata_b
);
  logic [31:0] registers [32];

  always_ff @(posedge clk) begin
    if (i_we && (i_waddr != 5'd0)) registers[i_waddr] <= i_wdata;
  end

  assign o_rdata_a = (i_raddr_a == 5'd0) ? 32'd0 : registers[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == 5'd0) ? 32'd0 : registers[i_raddr_b];
endmodule

module mips32_core #(
  parameter int unsigned IMEM_WORDS = 32,
  parameter int unsigned DMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_out
);
  localparam int unsigned IAW = $clog2(IMEM_WORDS);
  localparam int unsigned DAW = $clog2(DMEM_WORDS);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  logic [31:0] r_pc;
  logic [31:0] w_instr;
  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_z;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_sum_imm;
  logic [31:0] w_br_target;
  logic [31:0] w_jmp_target;
  logic [31:0] w_pc_next;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_rf_wdata;
  logic        w_dm_we;

  mips32_core_if #(.AW(IAW)) w_ibus ();
  mips32_core_if #(.AW(DAW)) w_dbus ();

  mips32_ram #(.WORDS(IMEM_WORDS)) imemory (
    .clk (clk),
    .bus (w_ibus)
  );

  mips32_ram #(.WORDS(DMEM_WORDS)) main_memory (
    .clk (clk),
    .bus (w_dbus)
  );

  mips32_regfile registers (
    .clk       (clk),
    .i_we      (w_rf_we & ~rst),
    .i_waddr   (w_rf_waddr),
    .i_wdata   (w_rf_wdata),
    .i_raddr_a (w_rs),
    .i_raddr_b (w_rt),
    .o_rdata_a (w_rs_val),
    .o_rdata_b (w_rt_val)
  );

  // Instruction port is read-only; the index drops pc[1:0] and wraps by truncation.
  assign w_ibus.we    = 1'b0;
  assign w_ibus.addr  = r_pc[IAW+1:2];
  assign w_ibus.wdata = 32'd0;
  assign w_instr      = w_ibus.rdata;

  assign w_op    = w_instr[31:26];
  assign w_rs    = w_instr[25:21];
  assign w_rt    = w_instr[20:16];
  assign w_rd    = w_instr[15:11];
  assign w_shamt = w_instr[10:6];
  assign w_funct = w_instr[5:0];
  assign w_imm_s = {{16{w_instr[15]}}, w_instr[15:0]};
  assign w_imm_z = {16'h0000, w_instr[15:0]};

  // One adder serves addi/addiu results and the load/store effective address.
  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_sum_imm    = w_rs_val + w_imm_s;
  assign w_br_target  = w_pc_plus4 + {w_imm_s[29:0], 2'b00};
  assign w_jmp_target = {w_pc_plus4[31:28], w_instr[25:0], 2'b00};

  assign w_dbus.we    = w_dm_we & ~rst;
  assign w_dbus.addr  = w_sum_imm[DAW+1:2];
  assign w_dbus.wdata = w_rt_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pc <= 32'd0;
    else     r_pc <= w_pc_next;
  end

  assign pc_out = r_pc;

  // Decode/execute: unknown op/funct falls through as a NOP.
  always_comb begin
    w_pc_next  = w_pc_plus4;
    w_rf_we    = 1'b0;
    w_rf_waddr = w_rt;
    w_rf_wdata = w_sum_imm;
    w_dm_we    = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_rf_we    = 1'b1;
        w_rf_waddr = w_rd;
        case (w_funct)
          FN_ADD, FN_ADDU: w_rf_wdata = w_rs_val + w_rt_val;
          FN_SUB, FN_SUBU: w_rf_wdata = w_rs_val - w_rt_val;
          FN_AND:          w_rf_wdata = w_rs_val & w_rt_val;
          FN_OR:           w_rf_wdata = w_rs_val | w_rt_val;
          FN_XOR:          w_rf_wdata = w_rs_val ^ w_rt_val;
          FN_NOR:          w_rf_wdata = ~(w_rs_val | w_rt_val);
          FN_SLT:          w_rf_wdata = {31'd0, $signed(w_rs_val) < $signed(w_rt_val)};
          FN_SLTU:         w_rf_wdata = {31'd0, w_rs_val < w_rt_val};
          FN_SLL:          w_rf_wdata = w_rt_val << w_shamt;
          FN_SRL:          w_rf_wdata = w_rt_val >> w_shamt;
          FN_SRA:          w_rf_wdata = 32'($signed(w_rt_val) >>> w_shamt);
          FN_JR: begin
            w_rf_we   = 1'b0;
            w_pc_next = w_rs_val;
          end
          default:         w_rf_we = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: w_rf_we = 1'b1;
      OP_SLTI: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = {31'd0, $signed(w_rs_val) < $signed(w_imm_s)};
      end
      OP_ANDI: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = w_rs_val & w_imm_z;
      end
      OP_ORI: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = w_rs_val | w_imm_z;
      end
      OP_XORI: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = w_rs_val ^ w_imm_z;
      end
      OP_LUI: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = {w_instr[15:0], 16'h0000};
      end
      OP_LW: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = w_dbus.rdata;
      end
      OP_SW:  w_dm_we = 1'b1;
      OP_BEQ: if (w_rs_val == w_rt_val) w_pc_next = w_br_target;
      OP_BNE: if (w_rs_val != w_rt_val) w_pc_next = w_br_target;
      OP_J:   w_pc_next = w_jmp_target;
      OP_JAL: begin
        w_pc_next  = w_jmp_target;
        w_rf_we    = 1'b1;
        w_rf_waddr = 5'd31;
        w_rf_wdata = w_pc_plus4;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mips32_core.sv
// Bench for mips32_core: directed program plus random programs checked against
// an instruction-level reference model of architectural state.
module tb_mips32_core;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_out;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] m_imem [32];
  logic [31:0] m_reg  [32];
  logic [31:0] m_dmem [32];
  logic [31:0] m_pc;

  localparam logic [5:0] R_FN [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                       6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
  localparam logic [5:0] I_OP [7]  = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F};

  mips32_core #(.IMEM_WORDS(32), .DMEM_WORDS(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .pc_out (pc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  // Instruction-set reference: one architectural step of the model state.
  task automatic model_step();
    logic [31:0] ins, a, b, se, ze, pc4, res, nxt;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, wa;
    int unsigned sh;
    bit          wr;
    ins = m_imem[m_pc[6:2]];
    op  = ins[31:26];
    rs  = ins[25:21];
    rt  = ins[20:16];
    rd  = ins[15:11];
    sh  = int'(ins[10:6]);
    fn  = ins[5:0];
    a   = m_reg[rs];
    b   = m_reg[rt];
    se  = {{16{ins[15]}}, ins[15:0]};
    ze  = {16'h0000, ins[15:0]};
    pc4 = m_pc + 32'd4;
    nxt = pc4;
    wr  = 1'b0;
    wa  = rt;
    res = 32'd0;
    case (op)
      6'h00: begin
        wa = rd;
        wr = 1'b1;
        case (fn)
          6'h20, 6'h21: res = a + b;
          6'h22, 6'h23: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h26: res = a ^ b;
          6'h27: res = ~(a | b);
          6'h2A: res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
          6'h2B: res = (a < b) ? 32'd1 : 32'd0;
          6'h00: res = b << sh;
          6'h02: res = b >> sh;
          6'h03: res = 32'(int'(b) >>> sh);
          6'h08: begin wr = 1'b0; nxt = a; end
          default: wr = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin wr = 1'b1; res = a + se; end
      6'h0A: begin wr = 1'b1; res = (int'(a) < int'(se)) ? 32'd1 : 32'd0; end
      6'h0C: begin wr = 1'b1; res = a & ze; end
      6'h0D: begin wr = 1'b1; res = a | ze; end
      6'h0E: begin wr = 1'b1; res = a ^ ze; end
      6'h0F: begin wr = 1'b1; res = ze * 32'd65536; end
      6'h23: begin wr = 1'b1; res = m_dmem[((a + se) / 32'd4) % 32'd32]; end
      6'h2B: m_dmem[((a + se) / 32'd4) % 32'd32] = b;
      6'h04: if (a == b) nxt = pc4 + se * 32'd4;
      6'h05: if (a != b) nxt = pc4 + se * 32'd4;
      6'h02: nxt = (pc4 & 32'hF000_0000) | ({6'd0, ins[25:0]} * 32'd4);
      6'h03: begin
        nxt = (pc4 & 32'hF000_0000) | ({6'd0, ins[25:0]} * 32'd4);
        wr  = 1'b1;
        wa  = 5'd31;
        res = pc4;
      end
      default: ;
    endcase
    if (wr && wa != 5'd0) m_reg[wa] = res;
    m_pc = nxt;
  endtask

  function automatic logic [31:0] rand_val();
    if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 40));
    return 32'($urandom());
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    int          k, idx;
    rs  = 5'($urandom());
    rt  = 5'($urandom());
    rd  = 5'($urandom());
    sh  = 5'($urandom());
    imm = 16'($urandom());
    k   = int'($urandom_range(0, 15));
    if (k <= 3) begin
      idx = int'($urandom_range(0, 12));
      return enc_r(rs, rt, rd, sh, R_FN[idx]);
    end
    if (k <= 6) begin
      idx = int'($urandom_range(0, 6));
      return enc_i(I_OP[idx], rs, rt, imm);
    end
    if (k == 7) return enc_i(6'h23, rs, rt, imm);
    if (k == 8) return enc_i(6'h2B, rs, rt, imm);
    if (k == 9) return enc_i(($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05,
                             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                             16'(int'($urandom_range(0, 8)) - 4));
    if (k == 10) return enc_j(6'h02, 26'($urandom_range(0, 31)));
    if (k == 11) return enc_j(6'h03, 26'($urandom()));
    if (k == 12) return enc_r(rs, 5'd0, 5'd0, 5'd0, 6'h08);
    if (k == 13) return 32'($urandom());
    return enc_r(rs, rt, rd, sh, 6'($urandom()));
  endfunction

  task automatic load_dut();
    for (int i = 0; i < 32; i++) begin
      dut.imemory.memory[i]         = m_imem[i];
      dut.main_memory.memory[i]     = m_dmem[i];
      dut.registers.registers[i]    = m_reg[i];
    end
  endtask

  task automatic compare_state(input string tag);
    for (int i = 1; i < 32; i++)
      check($sformatf("%s_r%0d", tag, i), dut.registers.registers[i], m_reg[i]);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s_mem%0d", tag, i), dut.main_memory.memory[i], m_dmem[i]);
  endtask

  initial begin
    logic [31:0] trace [$];

    #1 rst = 1'b1;
    #1 check("reset_pc", pc_out, 32'h0);

    for (int i = 0; i < 32; i++) begin
      m_imem[i] = 32'd0;
      m_reg[i]  = 32'd0;
      m_dmem[i] = 32'd0;
    end
    m_reg[1]   = 32'd5;
    m_reg[2]   = 32'd7;
    m_imem[0]  = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    m_imem[1]  = enc_r(5'd1, 5'd2, 5'd4, 5'd0, 6'h22);
    m_imem[2]  = enc_r(5'd1, 5'd2, 5'd5, 5'd0, 6'h2A);
    m_imem[3]  = enc_i(6'h0F, 5'd0, 5'd6, 16'h1234);
    m_imem[4]  = enc_i(6'h0D, 5'd6, 5'd6, 16'h5678);
    m_imem[5]  = enc_i(6'h08, 5'd0, 5'd7, 16'hFFFF);
    m_imem[6]  = enc_i(6'h2B, 5'd0, 5'd6, 16'd8);
    m_imem[7]  = enc_i(6'h23, 5'd0, 5'd8, 16'd8);
    m_imem[8]  = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
    m_imem[11] = enc_i(6'h05, 5'd1, 5'd1, 16'd5);
    m_imem[12] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
    m_imem[13] = enc_j(6'h03, 26'h10);
    m_imem[14] = enc_j(6'h02, 26'h11);
    m_imem[16] = enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
    load_dut();
    m_pc = 32'd0;

    // Expected PC after each retired instruction, ending past the 0x80 wrap.
    for (int a = 4; a <= 32'h20; a += 4) trace.push_back(32'(a));
    trace.push_back(32'h2C); trace.push_back(32'h30); trace.push_back(32'h34);
    trace.push_back(32'h40); trace.push_back(32'h38); trace.push_back(32'h44);
    for (int a = 32'h48; a <= 32'h84; a += 4) trace.push_back(32'(a));

    @(negedge clk) rst = 1'b0;
    foreach (trace[k]) begin
      model_step();
      @(posedge clk);
      #1 check($sformatf("dir_pc%0d", k), pc_out, trace[k]);
    end
    check("add_r3",  dut.registers.registers[3],  32'd12);
    check("sub_r4",  dut.registers.registers[4],  32'hFFFF_FFFE);
    check("slt_r5",  dut.registers.registers[5],  32'd1);
    check("lui_ori_r6", dut.registers.registers[6], 32'h1234_5678);
    check("addi_r7", dut.registers.registers[7],  32'hFFFF_FFFF);
    check("sw_mem2", dut.main_memory.memory[2],   32'h1234_5678);
    check("lw_r8",   dut.registers.registers[8],  32'h1234_5678);
    check("r0_zero", dut.registers.registers[0],  32'd0);
    check("jal_r31", dut.registers.registers[31], 32'h38);
    compare_state("dir");

    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst_pc", pc_out, 32'h0);
    check("rst_keeps_r6", dut.registers.registers[6], 32'h1234_5678);
    check("rst_keeps_mem2", dut.main_memory.memory[2], 32'h1234_5678);
    @(posedge clk);
    #1 check("rst_hold_pc", pc_out, 32'h0);
    check("rst_hold_r31", dut.registers.registers[31], 32'h38);

    for (int p = 0; p < 6; p++) begin
      @(negedge clk) rst = 1'b1;
      for (int i = 0; i < 32; i++) begin
        m_imem[i] = rand_instr();
        m_reg[i]  = rand_val();
        m_dmem[i] = rand_val();
      end
      m_reg[0] = 32'd0;
      load_dut();
      dut.registers.registers[0] = 32'($urandom()) | 32'h1;
      m_pc = 32'd0;
      #1 check($sformatf("rnd%0d_reset_pc", p), pc_out, 32'h0);
      @(negedge clk) rst = 1'b0;
      for (int c = 0; c < 150; c++) begin
        model_step();
        @(posedge clk);
        #1 check($sformatf("rnd%0d_pc%0d", p, c), pc_out, m_pc);
      end
      compare_state($sformatf("rnd%0d", p));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
